// File: rtl/frv_pipeline_fifo.sv
// DEPTH-entry valid/busy handshaked buffer between core pipeline stages.
// Carries a control payload plus a sticky operand lane loaded per push.
module frv_pipeline_fifo #(
    parameter int unsigned RLEN  = 42,
    parameter int unsigned OLEN  = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic [RLEN-1:0] i_data,
    input  logic [OLEN-1:0] i_opr,
    input  logic            i_opr_ld,
    input  logic            i_valid,
    output logic            o_busy,
    input  logic            flush,
    output logic [RLEN-1:0] mr_data,
    output logic [RLEN-1:0] o_data,
    output logic [OLEN-1:0] o_opr,
    output logic            o_valid,
    input  logic            i_busy,
    output logic [CW-1:0]   o_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [RLEN-1:0] data_q [DEPTH];
    logic [RLEN-1:0] data_d [DEPTH];
    logic [OLEN-1:0] opr_q  [DEPTH];
    logic [OLEN-1:0] opr_d  [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [OLEN-1:0] opr_hold_q, opr_hold_d;
    logic [RLEN-1:0] mr_data_q, mr_data_d;

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [OLEN-1:0] wr_opr;

    // Pointers wrap after DEPTH-1, so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    // A full buffer still accepts when the consumer drains the head this cycle.
    assign o_busy = full && i_busy;
    assign push   = i_valid && !o_busy && !flush;
    assign pop    = !empty && !i_busy && !flush;
    assign wr_opr = i_opr_ld ? i_opr : opr_hold_q;

    always_comb begin
        data_d     = data_q;
        opr_d      = opr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        opr_hold_d = opr_hold_q;
        mr_data_d  = mr_data_q;

        if (push) begin
            data_d[wr_ptr_q] = i_data;
            opr_d[wr_ptr_q]  = wr_opr;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
            mr_data_d        = i_data;
            if (i_opr_ld) begin
                opr_hold_d = i_opr;
            end
        end

        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Flush empties the buffer but keeps the sticky operand and mr tap.
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                opr_q[i]  <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            opr_hold_q <= '0;
            mr_data_q  <= '0;
        end else begin
            data_q     <= data_d;
            opr_q      <= opr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            opr_hold_q <= opr_hold_d;
            mr_data_q  <= mr_data_d;
        end
    end

    assign o_valid = !empty;
    assign o_count = count_q;
    assign o_data  = empty ? '0 : data_q[rd_ptr_q];
    assign o_opr   = empty ? opr_hold_q : opr_q[rd_ptr_q];
    assign mr_data = mr_data_q;

endmodule

// File: doc/frv_pipeline_fifo.md
# frv_pipeline_fifo

Parametrised successor to the single-entry inter-stage pipeline register: a DEPTH-entry, valid/busy handshaked buffer placed between core pipeline stages, e.g. execute to memory. It carries a control payload plus a separate operand lane whose load is gated per transfer, so unloaded operands hold the last loaded value. It adds configurable depth, an occupancy count, a most-recent-data tap and registered flush. It lets a stalled downstream stage absorb up to DEPTH results without back-pressuring the producer.

## Interface

Parameters:
- RLEN, 42: control payload width (rd, uop, fu, trap, size, instr).
- OLEN, 32: operand lane width.
- DEPTH, 2: number of entries. Legal range is 1 to 16.
- CW, $clog2(DEPTH+1): occupancy count width (derived).

Ports:
- g_clk  in  1  global clock.
- g_resetn  in  1  synchronous reset, active low.
- i_data  in  RLEN  control payload from stage N.
- i_opr  in  OLEN  operand value from stage N.
- i_opr_ld  in  1  operand load enable for this push.
- i_valid  in  1  stage N presents a transfer.
- o_busy  out  1  buffer cannot accept a transfer this cycle.
- flush  in  1  discard all buffered entries.
- mr_data  out  RLEN  payload of the most recent accepted push.
- o_data  out  RLEN  head payload to stage N+1.
- o_opr  out  OLEN  head operand to stage N+1.
- o_valid  out  1  head entry valid.
- i_busy  in  1  stage N+1 cannot accept.
- o_count  out  CW  number of occupied entries.

## Operation

- Storage is a circular buffer of DEPTH entries, each holding {payload, operand}.
- Pointers: rd_ptr and wr_ptr, each log2(DEPTH) bits, wrap modulo DEPTH. DEPTH need not be a power of two; a pointer wraps to 0 after DEPTH-1.
- Occupancy: count ranges 0 to DEPTH. o_count = count. o_valid = (count != 0).
- push = i_valid && !o_busy && !flush.
- pop = o_valid && !i_busy && !flush.
- o_busy = (count == DEPTH) && i_busy. When the buffer is full, a push is accepted in the same cycle as a pop. This path is combinational from i_busy to o_busy, as in the existing register.
- Count update: push only gives count+1; pop only gives count-1; both or neither leaves count unchanged.
- Sticky operand register opr_hold:
  - On a push with i_opr_ld=1, the entry stores i_opr and opr_hold <= i_opr.
  - On a push with i_opr_ld=0, the entry stores opr_hold.
  - When i_opr_ld=1 on a push, the written entry gets i_opr in that same cycle; opr_hold is never a stale value for that write.
- mr_data updates with i_data on every push and holds otherwise.
- Empty-buffer outputs: o_data = 0 and o_opr = opr_hold.
- flush:
  - Next cycle: count=0 and rd_ptr=wr_ptr=0. A push or pop in the flush cycle is discarded.
  - opr_hold and mr_data are NOT cleared by flush.
- Reset: all pointers, count, opr_hold, mr_data and entries clear to 0.

## Timing

- Reset values: o_valid=0, o_count=0, o_data=0, o_opr=0, mr_data=0, o_busy=0.
- Latency: a push at edge N gives o_valid=1 after edge N. There is no combinational bypass from i_data to o_data.
- Throughput: one transfer per cycle sustained at any count, including count==DEPTH with a concurrent pop.
- Outputs o_data, o_opr, o_valid and o_count are registered or muxed from registered state only.
- Priority order: g_resetn over flush over push/pop.
- Reset asserted mid-burst: all entries are lost and no output valid is seen the next cycle.
- Flush arriving with i_valid=1: o_busy stays per the rule above, but the transfer is dropped. The producer must treat this as a kill, not an accept.
- DEPTH=1: the block behaves as the existing single-entry register with BUFFER_HANDSHAKE=0.

## Test plan

- Fill and drain:
  - Stimulus: DEPTH=2, i_busy=1, push A=0x11 then B=0x22.
  - Required: o_count=2, o_busy=1, a third push is refused.
  - Then release i_busy: o_data shows 0x11, then 0x22, then o_valid=0.
- Full with concurrent pop:
  - Stimulus: count=2, i_busy=0, push C=0x33.
  - Required: o_busy=0, C is accepted, o_count stays 2, order A/B/C is preserved.
- Sticky operand:
  - Stimulus: push with i_opr_ld=1 and i_opr=0xDEADBEEF, then two pushes with i_opr_ld=0 and i_opr=0x5.
  - Required: all three entries pop with o_opr=0xDEADBEEF.
- Flush:
  - Stimulus: count=2, assert flush together with i_valid=1.
  - Required next cycle: o_count=0, o_valid=0, mr_data unchanged, o_opr = last loaded operand.
- Pointer wrap:
  - Stimulus: DEPTH=3, 10 random push/pop cycles with random i_busy.
  - Required: output order matches a reference queue and o_count never exceeds 3.
- Reset mid-operation:
  - Stimulus: count=2, pull g_resetn low for one cycle.
  - Required next cycle: all outputs at their reset values.
